jesd_link_ctrl: RTL and testbench

Link-establishment sequencer for a transmit lane. Drives the lane's `Data_Ctrl`, `Byte_Count` and `ILA_Cnt` inputs so the lane emits code-group synchronisation (CGS), then the initial lane alignment sequence (ILA), then user data. It tracks the multiframe (LMFC) boundary and reacts to the receiver's `sync_n` request. It sits between the link-level control and one or more lane instances, which share its outputs.

---
 rtl/jesd_link_ctrl.sv | 148 ++++++++++++++
 tb/tb_jesd_link_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jesd_link_ctrl.sv
// JESD204 transmit link-establishment sequencer: drives lane source select (CGS -> ILA -> DATA),
// tracks the LMFC boundary and reacts to the receiver's SYNC~ (error reports and re-sync).
module jesd_link_ctrl #(
    parameter int unsigned F          = 2,
    parameter int unsigned K          = 16,
    parameter int unsigned ILA_MF     = 4,
    parameter int unsigned RESYNC_LEN = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sync_n,
    output logic [2:0]  Data_Ctrl,
    output logic [31:0] Byte_Count,
    output logic [3:0]  ILA_Cnt,
    output logic        lmfc,
    output logic        link_up,
    output logic        data_req,
    output logic [7:0]  err_cnt
);
    localparam int unsigned FK = F * K;
    localparam int unsigned BW = $clog2(FK + 1);
    localparam int unsigned LW = $clog2(RESYNC_LEN + 1);
    localparam logic [BW-1:0] BC_LAST  = BW'(FK - 1);
    localparam logic [3:0]    ILA_LAST = 4'(ILA_MF - 1);
    localparam logic [LW-1:0] LOW_TRIP = LW'(RESYNC_LEN - 1);
    localparam logic [LW-1:0] LOW_SAT  = LW'(RESYNC_LEN);

    typedef enum logic [1:0] {S_IDLE, S_CGS, S_ILA, S_DATA} state_e;

    state_e        state_q, state_d, state_dd;
    logic          sync_q;
    logic [BW-1:0] byte_count_q, byte_count_d;
    logic [3:0]    ila_cnt_q, ila_cnt_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [2:0]    data_ctrl_q, data_ctrl_d;
    logic          lmfc_q, lmfc_d;
    logic          link_up_q, link_up_d;
    logic          data_req_q, data_req_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // Transition rule, shared by the real next state and the one-cycle look-ahead for data_req.
    function automatic state_e f_next_state(state_e s, logic [BW-1:0] bc, logic [3:0] ila,
                                            logic [LW-1:0] low, logic sync, logic en);
        state_e n;
        n = s;
        if (!en) begin
            n = S_IDLE;
        end else begin
            case (s)
                S_IDLE: n = S_CGS;
                S_CGS: begin
                    if (sync && bc == BC_LAST) n = S_ILA;
                end
                S_ILA: begin
                    if (!sync) n = S_CGS;
                    else if (ila == ILA_LAST && bc == BC_LAST) n = S_DATA;
                end
                S_DATA: begin
                    if (!sync && low == LOW_TRIP) n = S_CGS;
                end
                default: n = S_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic logic [3:0] f_next_ila(state_e s, state_e n, logic [3:0] ila,
                                              logic [BW-1:0] bc);
        logic [3:0] r;
        r = '0;
        if (s == S_ILA && n == S_ILA) r = (bc == BC_LAST) ? ila + 4'd1 : ila;
        return r;
    endfunction

    // Consecutive-low counter only lives inside DATA; any exit or a high SYNC~ clears it.
    function automatic logic [LW-1:0] f_next_low(state_e s, state_e n, logic [LW-1:0] low,
                                                 logic sync);
        logic [LW-1:0] r;
        r = '0;
        if (s == S_DATA && n == S_DATA && !sync) r = (low == LOW_SAT) ? low : low + LW'(1);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = f_next_state(state_q, byte_count_q, ila_cnt_q, low_cnt_q, sync_q, enable);
    end

    // sync_n is next cycle's sync_q, so the look-ahead is exact unless enable changes.
    always_comb begin
        byte_count_d = (byte_count_q == BC_LAST) ? '0 : byte_count_q + BW'(1);
        ila_cnt_d    = f_next_ila(state_q, state_d, ila_cnt_q, byte_count_q);
        low_cnt_d    = f_next_low(state_q, state_d, low_cnt_q, sync_q);
        state_dd     = f_next_state(state_d, byte_count_d, ila_cnt_d, low_cnt_d, sync_n, enable);
        data_ctrl_d  = 3'b001;
        case (state_d)
            S_ILA:   data_ctrl_d = 3'b010;
            S_DATA:  data_ctrl_d = 3'b100;
            default: data_ctrl_d = 3'b001;
        endcase
        lmfc_d     = (byte_count_d == '0);
        link_up_d  = (state_d == S_DATA);
        data_req_d = (state_dd == S_DATA);
        err_cnt_d  = err_cnt_q;
        if (state_q == S_DATA && sync_q && low_cnt_q != '0 && low_cnt_q != LOW_SAT
            && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= 1'b0;
            byte_count_q <= '0;
            ila_cnt_q    <= '0;
            low_cnt_q    <= '0;
            data_ctrl_q  <= 3'b001;
            lmfc_q       <= 1'b0;
            link_up_q    <= 1'b0;
            data_req_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            sync_q       <= sync_n;
            byte_count_q <= byte_count_d;
            ila_cnt_q    <= ila_cnt_d;
            low_cnt_q    <= low_cnt_d;
            data_ctrl_q  <= data_ctrl_d;
            lmfc_q       <= lmfc_d;
            link_up_q    <= link_up_d;
            data_req_q   <= data_req_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign Data_Ctrl  = data_ctrl_q;
    assign Byte_Count = 32'(byte_count_q);
    assign ILA_Cnt    = ila_cnt_q;
    assign lmfc       = lmfc_q;
    assign link_up    = link_up_q;
    assign data_req   = data_req_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_jesd_link_ctrl.sv
// Directed bench for jesd_link_ctrl (F=2, K=16, ILA_MF=4, RESYNC_LEN=17); outputs sampled on negedge.
module tb_jesd_link_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sync_n;
    logic [2:0]  Data_Ctrl;
    logic [31:0] Byte_Count;
    logic [3:0]  ILA_Cnt;
    logic        lmfc;
    logic        link_up;
    logic        data_req;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jesd_link_ctrl #(.F(2), .K(16), .ILA_MF(4), .RESYNC_LEN(17)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sync_n     (sync_n),
        .Data_Ctrl  (Data_Ctrl),
        .Byte_Count (Byte_Count),
        .ILA_Cnt    (ILA_Cnt),
        .lmfc       (lmfc),
        .link_up    (link_up),
        .data_req   (data_req),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tickn(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a given lane source select; expiry is reported as a failed check.
    task automatic wait_dc(input string tag, input logic [2:0] want, input int max_cyc,
                           output int waited);
        waited = 0;
        while (Data_Ctrl !== want && waited < max_cyc) begin
            tickn(1);
            waited++;
        end
        check(tag, 32'(Data_Ctrl === want), 32'd1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst_n  = 1'b0;
        enable = 1'b1;
        sync_n = 1'b0;
        tickn(3);
        check("rst_data_ctrl", 32'(Data_Ctrl), 32'h1);
        check("rst_byte_count", Byte_Count, 32'd0);
        check("rst_ila_cnt", 32'(ILA_Cnt), 32'd0);
        check("rst_lmfc", 32'(lmfc), 32'd0);
        check("rst_link_up", 32'(link_up), 32'd0);
        check("rst_data_req", 32'(data_req), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        rst_n = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            tickn(1);
            check("bc_count", Byte_Count, 32'(i % 32));
            if (i == 32) check("lmfc_at_wrap", 32'(lmfc), 32'd1);
            if (i == 31) check("lmfc_off_wrap", 32'(lmfc), 32'd0);
        end
        check("cgs_no_sync", 32'(Data_Ctrl), 32'h1);

        // Bring-up: SYNC~ rises at Byte_Count=5, ILA starts on the next LMFC.
        tickn(4);
        check("bc_before_sync", Byte_Count, 32'd5);
        sync_n = 1'b1;
        tickn(26);
        check("cgs_until_lmfc", 32'(Data_Ctrl), 32'h1);
        tickn(1);
        check("ila_start_dc", 32'(Data_Ctrl), 32'h2);
        check("ila_start_bc", Byte_Count, 32'd0);
        check("ila_start_cnt", 32'(ILA_Cnt), 32'd0);
        for (int j = 1; j <= 128; j++) begin
            tickn(1);
            if (j % 32 == 0 && j < 128) begin
                check("ila_cnt_step", 32'(ILA_Cnt), 32'(j / 32));
                check("ila_dc_hold", 32'(Data_Ctrl), 32'h2);
            end
            if (j == 126) check("data_req_not_yet", 32'(data_req), 32'd0);
            if (j == 127) begin
                check("data_req_rise", 32'(data_req), 32'd1);
                check("ila_last_link_up", 32'(link_up), 32'd0);
                check("ila_last_cnt", 32'(ILA_Cnt), 32'd3);
                check("ila_last_dc", 32'(Data_Ctrl), 32'h2);
            end
            if (j == 128) begin
                check("data_dc", 32'(Data_Ctrl), 32'h4);
                check("data_link_up", 32'(link_up), 32'd1);
                check("data_bc", Byte_Count, 32'd0);
                check("data_ila_cnt", 32'(ILA_Cnt), 32'd0);
                check("data_lmfc", 32'(lmfc), 32'd1);
            end
        end

        // Short SYNC~ pulses are error reports; count saturates at 255.
        for (int p = 0; p < 300; p++) begin
            sync_n = 1'b0;
            tickn(3);
            sync_n = 1'b1;
            tickn(3);
            if (p == 0) begin
                check("err_first", 32'(err_cnt), 32'd1);
                check("err_stay_data", 32'(Data_Ctrl), 32'h4);
                check("err_data_req", 32'(data_req), 32'd1);
            end
        end
        check("err_saturate", 32'(err_cnt), 32'd255);
        check("err_link_up", 32'(link_up), 32'd1);

        // Long SYNC~ low forces re-synchronisation.
        sync_n = 1'b0;
        tickn(16);
        check("resync_req_hold", 32'(data_req), 32'd1);
        tickn(1);
        check("resync_not_yet", 32'(Data_Ctrl), 32'h4);
        check("resync_req_drop", 32'(data_req), 32'd0);
        tickn(1);
        check("resync_cgs", 32'(Data_Ctrl), 32'h1);
        check("resync_link_down", 32'(link_up), 32'd0);
        sync_n = 1'b1;
        wait_dc("resync_ila_seen", 3'b010, 80, w);
        check("resync_ila_bc", Byte_Count, 32'd0);
        check("resync_ila_cnt", 32'(ILA_Cnt), 32'd0);
        check("resync_ila_latency", 32'(w >= 2), 32'd1);

        // Abort during ILA multiframe 2.
        tickn(64);
        check("abort_mf2", 32'(ILA_Cnt), 32'd2);
        tickn(5);
        sync_n = 1'b0;
        tickn(1);
        check("abort_not_yet", 32'(Data_Ctrl), 32'h2);
        tickn(1);
        check("abort_cgs", 32'(Data_Ctrl), 32'h1);
        check("abort_ila_cnt", 32'(ILA_Cnt), 32'd0);
        sync_n = 1'b1;
        wait_dc("reila_seen", 3'b010, 80, w);
        tickn(128);
        check("reila_data", 32'(Data_Ctrl), 32'h4);
        check("reila_link_up", 32'(link_up), 32'd1);

        // Enable drop in DATA.
        enable = 1'b0;
        sync_n = 1'b0;
        tickn(1);
        check("en_drop_dc", 32'(Data_Ctrl), 32'h1);
        check("en_drop_link", 32'(link_up), 32'd0);
        check("en_drop_req", 32'(data_req), 32'd0);
        check("en_drop_err_kept", 32'(err_cnt), 32'd255);
        tickn(3);
        enable = 1'b1;
        tickn(40);
        check("en_cgs_wait", 32'(Data_Ctrl), 32'h1);
        sync_n = 1'b1;
        wait_dc("en_ila_seen", 3'b010, 80, w);
        check("en_ila_bc", Byte_Count, 32'd0);

        // Synchronous reset mid-ILA.
        tickn(10);
        rst_n = 1'b0;
        tickn(1);
        check("mid_rst_dc", 32'(Data_Ctrl), 32'h1);
        check("mid_rst_bc", Byte_Count, 32'd0);
        check("mid_rst_ila", 32'(ILA_Cnt), 32'd0);
        check("mid_rst_lmfc", 32'(lmfc), 32'd0);
        check("mid_rst_err", 32'(err_cnt), 32'd0);
        check("mid_rst_req", 32'(data_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
